// File: rtl/jtag_gpr_access.sv
// Debug-side GPR access engine for the register file's JTAG port.
// Waits for core halt, performs one read or write per command, and verifies each write by read-back.
module jtag_gpr_access #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned CPU_WIDTH      = 32,
    parameter int unsigned HALT_TIMEOUT   = 256,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_write_i,
    input  logic [REG_ADDR_WIDTH-1:0] cmd_regno_i,
    input  logic [CPU_WIDTH-1:0]      cmd_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [CPU_WIDTH-1:0]      rsp_rdata_o,
    output logic [1:0]                rsp_err_o,
    input  logic                      core_halted_i,
    output logic                      jtag_we_o,
    output logic [REG_ADDR_WIDTH-1:0] jtag_addr_o,
    output logic [CPU_WIDTH-1:0]      jtag_data_o,
    input  logic [CPU_WIDTH-1:0]      jtag_data_i
);

    localparam int unsigned TO_W = (HALT_TIMEOUT > 1) ? $clog2(HALT_TIMEOUT) : 1;
    localparam int unsigned RT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(HALT_TIMEOUT - 1);
    localparam logic [RT_W-1:0] RT_MAX  = RT_W'(MAX_RETRY);

    localparam logic [1:0] ERR_OK     = 2'd0;
    localparam logic [1:0] ERR_HALT   = 2'd1;
    localparam logic [1:0] ERR_VERIFY = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_HALT,
        READ,
        WRITE,
        VERIFY,
        RESP
    } state_t;

    state_t                    state;
    logic [TO_W-1:0]           to_cnt;
    logic [RT_W-1:0]           rt_cnt;
    logic                      cmd_write;
    logic [REG_ADDR_WIDTH-1:0] cmd_regno;
    logic [CPU_WIDTH-1:0]      cmd_wdata;

    // Command sequencing; response payload is registered and held after the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            to_cnt      <= '0;
            rt_cnt      <= '0;
            cmd_write   <= 1'b0;
            cmd_regno   <= '0;
            cmd_wdata   <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= ERR_OK;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        cmd_write <= cmd_write_i;
                        cmd_regno <= cmd_regno_i;
                        cmd_wdata <= cmd_wdata_i;
                        to_cnt    <= '0;
                        rt_cnt    <= '0;
                        state     <= WAIT_HALT;
                    end
                end
                WAIT_HALT: begin
                    if (core_halted_i) begin
                        if (!cmd_write) begin
                            state <= READ;
                        end else if (cmd_regno != '0) begin
                            state <= WRITE;
                        end else begin
                            // x0 is hardwired: report success without strobing.
                            rsp_rdata_o <= '0;
                            rsp_err_o   <= ERR_OK;
                            state       <= RESP;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= ERR_HALT;
                        state       <= RESP;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                READ: begin
                    if (!core_halted_i) begin
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= ERR_HALT;
                    end else begin
                        rsp_rdata_o <= jtag_data_i;
                        rsp_err_o   <= ERR_OK;
                    end
                    state <= RESP;
                end
                WRITE: begin
                    if (!core_halted_i) begin
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= ERR_HALT;
                        state       <= RESP;
                    end else begin
                        state <= VERIFY;
                    end
                end
                VERIFY: begin
                    if (!core_halted_i) begin
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= ERR_HALT;
                        state       <= RESP;
                    end else begin
                        rsp_rdata_o <= jtag_data_i;
                        if (jtag_data_i == cmd_wdata) begin
                            rsp_err_o <= ERR_OK;
                            state     <= RESP;
                        end else if (rt_cnt < RT_MAX) begin
                            // A core write won the port; try again.
                            rt_cnt <= rt_cnt + RT_W'(1);
                            state  <= WRITE;
                        end else begin
                            rsp_err_o <= ERR_VERIFY;
                            state     <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Port strobes and address are pure decodes of the state register.
    assign cmd_ready_o = (state == IDLE) && !rst;
    assign rsp_valid_o = (state == RESP);
    assign jtag_we_o   = (state == WRITE);
    assign jtag_addr_o = (state == IDLE) ? '0 : cmd_regno;
    assign jtag_data_o = (state == IDLE) ? '0 : cmd_wdata;

endmodule
